// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RV32I core: fetch/decode/execute/memory/writeback with trap.
// Optional retired-instruction counter and retire_cnt port enabled by defining CTRL_RETIRE_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic [2:0]       instr_type,
    output logic             alu_a_sel,
    output logic             alu_b_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause
`ifdef CTRL_RETIRE_CNT_EN
    ,
    output logic [CNT_W-1:0] retire_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    state_t          state_q, state_d;
    logic [6:0]      opc_q, opc_d;
    logic [2:0]      itype_q, itype_d;
    logic [1:0]      cause_q, cause_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic            retire;
    logic            timeout_hit;

    // mem_ready on the same cycle always beats the timeout
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TW'(TIMEOUT_CYCLES)) && !mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            itype_q <= '0;
            cause_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            itype_q <= itype_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        opc_d     = opc_q;
        itype_d   = itype_q;
        cause_d   = cause_q;
        cnt_d     = '0;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        alu_a_sel = 1'b0;
        alu_b_sel = 1'b0;
        reg_we    = 1'b0;
        wb_sel    = 2'b00;
        trap      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (timeout_hit) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_DECODE: begin
                opc_d   = opcode;
                state_d = S_EXEC;
                case (opcode)
                    OPC_LOAD, OPC_OPIMM, OPC_JALR: itype_d = 3'b000;
                    OPC_STORE:                     itype_d = 3'b001;
                    OPC_BRANCH:                    itype_d = 3'b010;
                    OPC_LUI, OPC_AUIPC:            itype_d = 3'b011;
                    OPC_JAL:                       itype_d = 3'b100;
                    OPC_OP:                        itype_d = 3'b101;
                    default: begin
                        opc_d   = opc_q;
                        cause_d = 2'b01;
                        state_d = S_TRAP;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_WB;
                case (opc_q)
                    OPC_OP: ;
                    OPC_AUIPC, OPC_JAL: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    OPC_BRANCH: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                        pc_we     = branch_taken;
                        pc_src    = 1'b1;
                        retire    = 1'b1;
                        state_d   = S_FETCH;
                    end
                    default: alu_b_sel = 1'b1;
                endcase
                if (opc_q == OPC_LOAD || opc_q == OPC_STORE) state_d = S_MEM;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opc_q == OPC_STORE);
                if (mem_ready) begin
                    retire  = (opc_q == OPC_STORE);
                    state_d = (opc_q == OPC_STORE) ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    cause_d = 2'b10;
                    state_d = S_TRAP;
                end else if (TIMEOUT_CYCLES != 0) begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            S_WB: begin
                reg_we  = 1'b1;
                retire  = 1'b1;
                state_d = S_FETCH;
                if (opc_q == OPC_LOAD) begin
                    wb_sel = 2'b01;
                end else if (opc_q == OPC_JAL || opc_q == OPC_JALR) begin
                    wb_sel = 2'b10;
                    pc_we  = 1'b1;
                    pc_src = 1'b1;
                end
            end
            S_TRAP:  trap = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

    assign instr_type = itype_q;
    assign trap_cause = cause_q;

`ifdef CTRL_RETIRE_CNT_EN
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retire_cnt_q <= '0;
        else        retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`else
    logic [CNT_W-1:0] unused_cnt_w;
    logic             unused_retire;
    assign unused_cnt_w  = '0;
    assign unused_retire = retire;
`endif

endmodule
